ascii_hex_parser: RTL

Receive-side counterpart of the hex-to-LCD character encoder: consumes a stream of LCD/ASCII character codes and reassembles hexadecimal words of up to `DIGITS` nibbles. Characters arrive over a valid/ready handshake; each completed word is presented on a valid/ready output with digit count and error status. It sits between a character source (keypad/UART/text buffer) and datapath logic that needs binary values.

---
 rtl/ascii_hex_pkg.sv | 33 +++
 rtl/ascii_hex_char_decode.sv | 39 +++
 rtl/ascii_hex_parser.sv | 126 ++++++++++++
 3 files changed

// File: rtl/ascii_hex_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ascii_hex_pkg
//  Description : Shared types and character constants for the ASCII hex
//                word parser.
//  Revision    : 1.0 - initial release
// ============================================================================
package ascii_hex_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_DISCARD = 2'd2,
        ST_EMIT    = 2'd3
    } state_e;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_BADCHAR  = 2'b01;
    localparam logic [1:0] ERR_OVERFLOW = 2'b10;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;

    localparam logic [7:0] CH_DIGIT_LO = 8'h30;
    localparam logic [7:0] CH_DIGIT_HI = 8'h39;
    localparam logic [7:0] CH_LOWER_LO = 8'h61;
    localparam logic [7:0] CH_LOWER_HI = 8'h66;
    localparam logic [7:0] CH_UPPER_LO = 8'h41;
    localparam logic [7:0] CH_UPPER_HI = 8'h46;

endpackage
`default_nettype wire

// File: rtl/ascii_hex_char_decode.sv
`default_nettype none
// ============================================================================
//  Module      : ascii_hex_char_decode
//  Description : Combinational classifier turning a character code into a
//                hex nibble plus digit / delimiter flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module ascii_hex_char_decode
    import ascii_hex_pkg::*;
(
    input  logic [7:0] char_code,
    output logic [3:0] nibble,
    output logic       is_digit,
    output logic       is_delim
);

    logic w_dec;
    logic w_lower;
    logic w_upper;

    assign w_dec   = (char_code >= CH_DIGIT_LO) && (char_code <= CH_DIGIT_HI);
    assign w_lower = (char_code >= CH_LOWER_LO) && (char_code <= CH_LOWER_HI);
    assign w_upper = (char_code >= CH_UPPER_LO) && (char_code <= CH_UPPER_HI);

    always_comb begin
        nibble   = 4'd0;
        is_digit = w_dec || w_lower || w_upper;
        is_delim = (char_code == CH_SPACE) || (char_code == CH_CR) ||
                   (char_code == CH_LF);
        if (w_dec) begin
            nibble = char_code[3:0];
        end else if (w_lower || w_upper) begin
            // Letters 'a'..'f' / 'A'..'F' have low nibble 1..6.
            nibble = char_code[3:0] + 4'd9;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ascii_hex_parser.sv
`default_nettype none
// ============================================================================
//  Module      : ascii_hex_parser
//  Description : Reassembles delimiter-separated hex words from a character
//                stream and presents them on a valid/ready output.
//  Revision    : 1.0 - initial release
// ============================================================================
module ascii_hex_parser
    import ascii_hex_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   in_char,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [4*DIGITS-1:0]          out_value,
    output logic [$clog2(DIGITS+1)-1:0]  out_count,
    output logic [1:0]                   out_err,
    output logic                         out_valid,
    input  logic                         out_ready
);

    localparam int VALUE_W = 4 * DIGITS;
    localparam int COUNT_W = $clog2(DIGITS + 1);

    state_e               state_q, state_d;
    logic [VALUE_W-1:0]   value_q, value_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic [1:0]           err_q,   err_d;
    logic                 valid_q, valid_d;

    logic [3:0]           w_nibble;
    logic                 w_is_digit;
    logic                 w_is_delim;
    logic                 w_take;

    ascii_hex_char_decode u_decode (
        .char_code (in_char),
        .nibble    (w_nibble),
        .is_digit  (w_is_digit),
        .is_delim  (w_is_delim)
    );

    assign in_ready = !rst && (state_q != ST_EMIT);
    assign w_take   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        value_d = value_q;
        count_d = count_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (w_take) begin
                    if (w_is_digit) begin
                        value_d = VALUE_W'(w_nibble);
                        count_d = COUNT_W'(1);
                        state_d = ST_ACCUM;
                    end else if (!w_is_delim) begin
                        err_d   = ERR_BADCHAR;
                        state_d = ST_DISCARD;
                    end
                end
            end
            ST_ACCUM: begin
                if (w_take) begin
                    if (w_is_digit) begin
                        if (count_q == COUNT_W'(DIGITS)) begin
                            err_d   = ERR_OVERFLOW;
                            state_d = ST_DISCARD;
                        end else begin
                            value_d = (value_q << 4) | VALUE_W'(w_nibble);
                            count_d = count_q + COUNT_W'(1);
                        end
                    end else if (w_is_delim) begin
                        state_d = ST_EMIT;
                    end else begin
                        err_d   = ERR_BADCHAR;
                        state_d = ST_DISCARD;
                    end
                end
            end
            ST_DISCARD: begin
                // The error recorded on entry is kept; only a delimiter ends the word.
                if (w_take && w_is_delim) begin
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    value_d = '0;
                    count_d = '0;
                    err_d   = ERR_NONE;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        valid_d = (state_d == ST_EMIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            value_q <= '0;
            count_q <= '0;
            err_q   <= ERR_NONE;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            count_q <= count_d;
            err_q   <= err_d;
            valid_q <= valid_d;
        end
    end

    assign out_value = value_q;
    assign out_count = count_q;
    assign out_err   = err_q;
    assign out_valid = valid_q;

endmodule
`default_nettype wire
